// File: rtl/arb_pkg.sv
// Shared types and sizes for the four-requester round-robin arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package arb_pkg;

    localparam int N_REQ = 4;
    localparam int ID_W  = 2;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

endpackage

// File: rtl/dec2to4_en.sv
// Enable-gated 2-to-4 one-hot decoder.
// Latency: combinational.
// Backpressure: none; output is all zero whenever en is low.
//
// Ports:
//   en   - decoder enable
//   sel  - 2-bit select
//   dout - one-hot output, zero when en=0
module dec2to4_en
    import arb_pkg::*;
(
    input  logic             en,
    input  logic [ID_W-1:0]  sel,
    output logic [N_REQ-1:0] dout
);

    always_comb begin
        dout = '0;
        if (en) begin
            dout[sel] = 1'b1;
        end
    end

endmodule

// File: rtl/rr_arbiter4.sv
// Four-requester round-robin arbiter; one grant at a time, held until released.
// Latency: grant registered one edge after req is sampled in IDLE; release one edge after done/req drop.
// Backpressure: owner holds the grant via its req line; done or req drop releases, one IDLE cycle between grants.
//
// Ports:
//   clk, rst_n - clock, asynchronous active-low reset
//   en         - arbitration enable (gates new grants only)
//   req[3:0]   - level-sensitive request lines
//   done       - owner releases the current grant
//   gnt[3:0]   - one-hot grant, gnt_id - owner index, gnt_valid - grant active
//   timeout    - one-cycle pulse after a forced release
// Optional feature: define ARB_TIMEOUT_EN to build the HOLD_MAX hold-limit counter.
module rr_arbiter4
    import arb_pkg::*;
#(
    parameter int HOLD_MAX = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [N_REQ-1:0] req,
    input  logic             done,
    output logic [N_REQ-1:0] gnt,
    output logic [ID_W-1:0]  gnt_id,
    output logic             gnt_valid,
    output logic             timeout
);

    if (HOLD_MAX < 2 || HOLD_MAX > 255) begin : g_bad_hold_max
        $error("rr_arbiter4: HOLD_MAX must be in 2..255");
    end

    // Returns {found, index}: first set request searching last+1 .. last+4 (mod 4),
    // so the most recent owner has the lowest priority.
    function automatic logic [ID_W:0] rr_pick(input logic [N_REQ-1:0] r,
                                              input logic [ID_W-1:0]  last);
        logic            found;
        logic [ID_W-1:0] idx;
        logic [ID_W-1:0] cand;
        found = 1'b0;
        idx   = last;
        for (int i = 1; i <= N_REQ; i++) begin
            cand = last + ID_W'(i);
            if (!found && r[cand]) begin
                found = 1'b1;
                idx   = cand;
            end
        end
        return {found, idx};
    endfunction

    state_t          state_q, state_d;
    logic [ID_W-1:0] gnt_id_q, gnt_id_d;
    logic [ID_W-1:0] last_q, last_d;
    logic [ID_W:0]   pick;
    logic            rel_norm;
    logic            timeout_hit;

    assign pick     = rr_pick(req, last_q);
    assign rel_norm = done || !req[gnt_id_q];

`ifdef ARB_TIMEOUT_EN
    logic [7:0] hold_cnt_q, hold_cnt_d;
    logic       timeout_q, timeout_d;

    assign timeout_hit = (state_q == ST_GRANT) && (hold_cnt_q == 8'(HOLD_MAX - 1));

    always_comb begin
        // Counting only in GRANT keeps the counter at zero on entry.
        hold_cnt_d = '0;
        if (state_q == ST_GRANT) begin
            hold_cnt_d = hold_cnt_q + 8'd1;
        end
        // A normal release on the same edge wins, so no timeout pulse.
        timeout_d = timeout_hit && !rel_norm;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_cnt_q <= '0;
            timeout_q  <= 1'b0;
        end else begin
            hold_cnt_q <= hold_cnt_d;
            timeout_q  <= timeout_d;
        end
    end

    assign timeout = timeout_q;
`else
    assign timeout_hit = 1'b0;
    assign timeout     = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        gnt_id_d = gnt_id_q;
        last_d   = last_q;
        case (state_q)
            ST_IDLE: begin
                // done is ignored here; only en and req matter.
                if (en && pick[ID_W]) begin
                    state_d  = ST_GRANT;
                    gnt_id_d = pick[ID_W-1:0];
                end
            end
            ST_GRANT: begin
                // en is deliberately not looked at: a live grant is never aborted.
                if (rel_norm || timeout_hit) begin
                    state_d = ST_IDLE;
                    last_d  = gnt_id_q;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            gnt_id_q <= '0;
            last_q   <= '1;
        end else begin
            state_q  <= state_d;
            gnt_id_q <= gnt_id_d;
            last_q   <= last_d;
        end
    end

    // Decoded straight from the state flop so an async reset drops gnt at once.
    assign gnt_valid = (state_q == ST_GRANT);
    assign gnt_id    = gnt_id_q;

    dec2to4_en u_dec (
        .en   (gnt_valid),
        .sel  (gnt_id_q),
        .dout (gnt)
    );

endmodule

// File: tb/tb_rr_arbiter4.sv
module tb_rr_arbiter4;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic [3:0] req;
    logic       done;
    logic [3:0] gnt;
    logic [1:0] gnt_id;
    logic       gnt_valid;
    logic       timeout;

    int n_chk;
    int n_bad;

    rr_arbiter4 #(.HOLD_MAX(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .req       (req),
        .done      (done),
        .gnt       (gnt),
        .gnt_id    (gnt_id),
        .gnt_valid (gnt_valid),
        .timeout   (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // exp_gnt is written out by hand at each call site.
    task automatic chk_gnt(input string tag, input logic v, input logic [1:0] id,
                           input logic [3:0] exp_gnt);
        check({tag, ".valid"}, 32'(gnt_valid), 32'(v));
        check({tag, ".gnt"}, 32'(gnt), 32'(exp_gnt));
        if (v) check({tag, ".id"}, 32'(gnt_id), 32'(id));
    endtask

    // Rotation with all requesters active and done held high.
    logic       rot_v  [9] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    logic [1:0] rot_id [9] = '{2'd0, 2'd0, 2'd1, 2'd0, 2'd2, 2'd0, 2'd3, 2'd0, 2'd0};
    logic [3:0] rot_g  [9] = '{4'b0001, 4'b0000, 4'b0010, 4'b0000, 4'b0100,
                               4'b0000, 4'b1000, 4'b0000, 4'b0001};

    initial begin
        n_chk = 0;
        n_bad = 0;
        rst_n = 1'b0;
        en    = 1'b0;
        req   = 4'b0000;
        done  = 1'b0;
        #12;
        chk_gnt("reset", 1'b0, 2'd0, 4'b0000);
        check("reset.id", 32'(gnt_id), 32'd0);
        check("reset.timeout", 32'(timeout), 32'd0);
        tick();
        rst_n = 1'b1;

        // last=3 after reset: req 0110 goes to 1, then 2 after done + idle cycle.
        en  = 1'b1;
        req = 4'b0110;
        tick();
        chk_gnt("b.first", 1'b1, 2'd1, 4'b0010);
        done = 1'b1;
        tick();
        chk_gnt("b.release", 1'b0, 2'd0, 4'b0000);
        done = 1'b0;
        tick();
        chk_gnt("b.second", 1'b1, 2'd2, 4'b0100);
        req = 4'b0000;
        tick();
        chk_gnt("b.drop", 1'b0, 2'd0, 4'b0000);

        // en gating of new grants only.
        en  = 1'b0;
        req = 4'b1000;
        tick();
        tick();
        chk_gnt("c.en_low", 1'b0, 2'd0, 4'b0000);
        en = 1'b1;
        tick();
        chk_gnt("c.en_high", 1'b1, 2'd3, 4'b1000);
        en = 1'b0;
        tick();
        tick();
        chk_gnt("c.en_drop_held", 1'b1, 2'd3, 4'b1000);
        done = 1'b1;
        tick();
        chk_gnt("c.done", 1'b0, 2'd0, 4'b0000);
        done = 1'b0;
        req  = 4'b0000;
        en   = 1'b1;
        tick();

        // Owner drops req without done; last becomes 0 so 1 wins next.
        req = 4'b0001;
        tick();
        chk_gnt("d.grant0", 1'b1, 2'd0, 4'b0001);
        req = 4'b0000;
        tick();
        chk_gnt("d.req_drop", 1'b0, 2'd0, 4'b0000);
        req = 4'b1111;
        tick();
        chk_gnt("d.last_is_0", 1'b1, 2'd1, 4'b0010);
        done = 1'b1;
        tick();
        done = 1'b0;
        tick();
        chk_gnt("d.grant2", 1'b1, 2'd2, 4'b0100);

        // Asynchronous reset mid-grant.
        #2;
        rst_n = 1'b0;
        #1;
        chk_gnt("e.async_rst", 1'b0, 2'd0, 4'b0000);
        check("e.async_rst.id", 32'(gnt_id), 32'd0);
        tick();
        rst_n = 1'b1;

        // Full rotation after reset, done held high.
        req  = 4'b1111;
        done = 1'b1;
        for (int i = 0; i < 9; i++) begin
            tick();
            chk_gnt($sformatf("e.rot%0d", i), rot_v[i], rot_id[i], rot_g[i]);
        end
        // Grant 0 live: done and req drop together give a single release.
        req = 4'b0000;
        tick();
        chk_gnt("f.both_release", 1'b0, 2'd0, 4'b0000);
        done = 1'b0;
        req  = 4'b1111;
        tick();
        chk_gnt("f.next_after_0", 1'b1, 2'd1, 4'b0010);
        done = 1'b1;
        req  = 4'b0000;
        tick();
        done = 1'b0;
        tick();

        // Hold limit with requester 1 holding and no done.
        req = 4'b0010;
        tick();
        chk_gnt("g.grant", 1'b1, 2'd1, 4'b0010);
`ifdef ARB_TIMEOUT_EN
        for (int i = 0; i < 3; i++) begin
            check($sformatf("g.to_low%0d", i), 32'(timeout), 32'd0);
            tick();
            chk_gnt($sformatf("g.hold%0d", i), 1'b1, 2'd1, 4'b0010);
        end
        tick();
        chk_gnt("g.forced", 1'b0, 2'd0, 4'b0000);
        check("g.timeout_pulse", 32'(timeout), 32'd1);
        tick();
        chk_gnt("g.regrant", 1'b1, 2'd1, 4'b0010);
        check("g.timeout_gone", 32'(timeout), 32'd0);
`else
        for (int i = 0; i < 12; i++) begin
            tick();
        end
        chk_gnt("g.held", 1'b1, 2'd1, 4'b0010);
        check("g.no_timeout", 32'(timeout), 32'd0);
`endif
        done = 1'b1;
        tick();
        chk_gnt("g.release", 1'b0, 2'd0, 4'b0000);
        check("g.timeout_end", 32'(timeout), 32'd0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
